// File: rtl/max_stream_reducer.sv
// Running-maximum reducer: folds a valid/ready operand stream into one max/count/overflow result per frame.
// Define MAX_ARGIDX_EN to add the out_idx port and the argmax index register.
module max_stream_reducer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
`ifdef MAX_ARGIDX_EN
  ,
  output logic [CNT_W-1:0] out_idx
`endif
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             first_q, first_d;
  logic             accept, deliver, sat;

  assign accept  = in_valid && (state_q == ACCUM);
  assign deliver = out_ready && (state_q == HOLD);
  assign sat     = (count_q == CNT_SAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (accept && in_last) state_d = HOLD;
      HOLD:    if (out_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Handshake flags come straight from the state register, so no input reaches an output combinationally.
  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == HOLD);
  end

  always_comb begin
    max_d   = max_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    first_d = first_q;
    if (accept) begin
      first_d = 1'b0;
      if (first_q) begin
        max_d   = in_data;
        count_d = CNT_W'(1);
        ovf_d   = 1'b0;
      end else begin
        if (in_data > max_q) max_d = in_data;
        if (sat) ovf_d = 1'b1;
        else     count_d = count_q + CNT_W'(1);
      end
    end else if (deliver) begin
      first_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      first_q <= 1'b1;
    end else begin
      max_q   <= max_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      first_q <= first_d;
    end
  end

  assign out_max   = max_q;
  assign out_count = count_q;
  assign out_ovf   = ovf_q;

`ifdef MAX_ARGIDX_EN
  logic [CNT_W-1:0] idx_q, idx_d;

  // count_q never exceeds its saturation value, so it doubles as the saturated position of the new beat.
  always_comb begin
    idx_d = idx_q;
    if (accept) begin
      if (first_q)              idx_d = '0;
      else if (in_data > max_q) idx_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign out_idx = idx_q;
`endif

endmodule

// File: tb/tb_max_stream_reducer.sv
// Scoreboard bench for max_stream_reducer: directed frames plus randomized frames checked by a frame-level model.
// Define MAX_ARGIDX_EN to also check out_idx.
module tb_max_stream_reducer;

  localparam int WIDTH = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_max;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;
`ifdef MAX_ARGIDX_EN
  logic [CNT_W-1:0] out_idx;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] mx;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic [CNT_W-1:0] idx;
  } res_t;

  res_t expQ[$];
  int   frame[$];
  int   stim[$];
  int   checks = 0;
  int   errors = 0;

  max_stream_reducer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_count (out_count),
    .out_ovf   (out_ovf)
`ifdef MAX_ARGIDX_EN
    ,
    .out_idx   (out_idx)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame result from first principles: largest value, earliest position of it, element count clipped at the counter range.
  function automatic res_t modelFrame();
    res_t r;
    int   best = -1;
    int   pos  = 0;
    foreach (frame[i]) begin
      if (frame[i] > best) begin
        best = frame[i];
        pos  = i;
      end
    end
    r.mx  = WIDTH'(best);
    r.idx = CNT_W'((pos > CMAX) ? CMAX : pos);
    r.cnt = CNT_W'((frame.size() > CMAX) ? CMAX : frame.size());
    r.ovf = (frame.size() > CMAX);
    return r;
  endfunction

  // Monitor: a result handshake completes at the next rising edge whenever valid and ready are both seen here.
  always @(negedge clk) begin
    res_t e;
    if (!rst && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_result", 1, 0);
      end else begin
        e = expQ.pop_front();
        checkOutput("out_max", int'(out_max), int'(e.mx));
        checkOutput("out_count", int'(out_count), int'(e.cnt));
        checkOutput("out_ovf", int'(out_ovf), int'(e.ovf));
`ifdef MAX_ARGIDX_EN
        checkOutput("out_idx", int'(out_idx), int'(e.idx));
`endif
      end
    end
  end

  task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic last, input bit stall);
    int n;
    if (stall) begin
      n = $urandom_range(0, 3);
      repeat (n) begin
        in_valid = 1'b0;
        in_data  = WIDTH'($urandom);
        in_last  = 1'($urandom);
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) checkOutput("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = WIDTH'($urandom);
    in_last  = 1'($urandom);
    frame.push_back(int'(d));
    if (last) begin
      expQ.push_back(modelFrame());
      frame.delete();
      checkOutput("latency_out_valid", int'(out_valid), 1);
      checkOutput("hold_in_ready", int'(in_ready), 0);
    end
  endtask

  task automatic waitReady(output int bubbles);
    bubbles = 0;
    while (!in_ready && bubbles < 100) begin
      @(posedge clk); #1;
      bubbles++;
    end
    if (!in_ready) checkOutput("ready_timeout", 0, 1);
  endtask

  // Sends stim as one frame, stalls the result for holdCycles, then expects exactly one bubble cycle.
  task automatic runFrame(input int holdCycles, input bit stall);
    int b;
    out_ready = (holdCycles == 0);
    foreach (stim[i]) applyStimulus(WIDTH'(stim[i]), (i == stim.size() - 1), stall);
    repeat (holdCycles) begin
      @(posedge clk); #1;
      checkOutput("stall_out_valid", int'(out_valid), 1);
      checkOutput("stall_in_ready", int'(in_ready), 0);
      checkOutput("stall_out_max", int'(out_max), int'(expQ[0].mx));
      checkOutput("stall_out_count", int'(out_count), int'(expQ[0].cnt));
    end
    out_ready = 1'b1;
    waitReady(b);
    checkOutput("bubble_cycles", b, 1);
  endtask

  initial begin
    int b;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", int'(in_ready), 1);
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_out_max", int'(out_max), 0);
    checkOutput("reset_out_count", int'(out_count), 0);
    checkOutput("reset_out_ovf", int'(out_ovf), 0);
`ifdef MAX_ARGIDX_EN
    checkOutput("reset_out_idx", int'(out_idx), 0);
`endif
    rst = 1'b0;

    stim = '{3, 9, 5, 9};
    runFrame(0, 1'b0);

    stim = '{7};
    runFrame(5, 1'b0);

    stim.delete();
    for (int i = 0; i < 17; i++) stim.push_back(i & 15);
    runFrame(0, 1'b0);

    stim = '{0, 15, 2};
    runFrame(0, 1'b1);

    out_ready = 1'b1;
    applyStimulus(WIDTH'(12), 1'b0, 1'b0);
    applyStimulus(WIDTH'(14), 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    frame.delete();
    checkOutput("abort_out_valid", int'(out_valid), 0);
    checkOutput("abort_in_ready", int'(in_ready), 1);
    checkOutput("abort_out_count", int'(out_count), 0);
    stim = '{4};
    runFrame(0, 1'b0);

    stim = '{1};
    runFrame(0, 1'b0);
    stim = '{8, 3};
    runFrame(0, 1'b0);

    for (int f = 0; f < 25; f++) begin
      stim.delete();
      for (int k = 0; k < int'($urandom_range(1, 20)); k++) stim.push_back($urandom_range(0, 15));
      runFrame($urandom_range(0, 3), 1'($urandom));
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("results_pending", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/max_stream_reducer.md
Name: max_stream_reducer

Overview:
- Sequential counterpart of the combinational max comparator partitions.
- Consumes a stream of unsigned operands, one per beat, over a valid/ready handshake.
- Keeps a running maximum per frame; a frame ends with the beat flagged `in_last`.
- Presents the frame maximum, element count and overflow flag on an output valid/ready handshake.
- Serves as the serial reference and driver when evaluating approximate max netlists against exact results.

Parameters:
- WIDTH, 4: operand width in bits, unsigned.
- CNT_W, 4: width of the element counter and of the index.

Ports:
- clk  input  1  Single clock; all logic is on the rising edge.
- rst  input  1  Synchronous, active-high reset.
- in_valid  input  1  Operand beat valid.
- in_ready  output  1  Block can accept an operand.
- in_data  input  WIDTH  Operand, unsigned.
- in_last  input  1  Marks the final operand of the frame.
- out_valid  output  1  Frame result valid.
- out_ready  input  1  Downstream accepts the result.
- out_max  output  WIDTH  Maximum of the frame.
- out_count  output  CNT_W  Number of operands accepted in the frame, saturating.
- out_ovf  output  1  Frame had more than 2^CNT_W-1 operands.
- out_idx  output  CNT_W  Position of the maximum. Present only with MAX_ARGIDX_EN.

Behaviour:
- States: ACCUM and HOLD.
- Reset (rst=1 at a clock edge) enters ACCUM with:
  - in_ready=1, out_valid=0.
  - out_max=0, out_count=0, out_ovf=0, out_idx=0.
  - Internal first-element flag set.
- Reset mid-frame or in HOLD discards the partial frame and any pending result. No output is produced for it.
- ACCUM:
  - in_ready=1 and out_valid=0.
  - A beat is accepted when in_valid && in_ready at the edge.
- On an accepted beat with the first flag set:
  - max<=in_data, idx<=0, count<=1, ovf<=0.
  - Clear the first flag.
- On an accepted beat with the first flag clear:
  - If in_data > max (strict unsigned), then max<=in_data and idx<=count (pre-increment value, saturated).
  - Ties keep the earlier position.
  - count increments and saturates at 2^CNT_W-1.
  - An accepted beat while count is already saturated sets ovf, which stays set for the frame.
- On an accepted beat with in_last=1:
  - Update as above, then move to HOLD on the same edge.
  - out_valid=1 from the next cycle.
  - Latency is one cycle from acceptance of the last beat to out_valid.
  - A single-beat frame (first beat with in_last=1) gives max=in_data, count=1, idx=0.
- HOLD:
  - in_ready=0 and out_valid=1.
  - out_max, out_count, out_ovf and out_idx hold stable until out_ready=1 at an edge.
  - On that edge: return to ACCUM, set the first flag, out_valid=0.
- The next frame's first beat is accepted no earlier than the cycle after the result handshake. This is a fixed one-cycle bubble.
- out_* values after the handshake retain the last result until overwritten. They are qualified only by out_valid.
- out_valid must never drop without out_ready.
- in_data and in_last are ignored when in_valid=0 or in_ready=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: MAX_ARGIDX_EN.
- Defined: the out_idx port and index register exist and behave as above.
- Undefined: no out_idx port and no index logic. All other ports and timing are identical.

Test Plan:
- Stream 3,9,5,9(last) with out_ready=1 (WIDTH=4): out_valid asserts one cycle after the last beat, with out_max=9, out_count=4, out_ovf=0, out_idx=1 (tie keeps earlier).
- Single beat 7 with in_last=1: out_max=7, out_count=1, out_idx=0. in_ready stays 0 while out_ready=0 for 5 cycles; outputs are stable throughout.
- 17 beats of value i (0..16), last on the 17th, with CNT_W=4: out_count=15, out_ovf=1, out_max=15 (i truncates, so 16 becomes 0), out_idx=15.
- Toggle in_valid randomly mid-frame over 0,15,2(last): stall cycles are ignored, out_max=15, out_idx=1.
- Assert rst after 2 beats of 12,14, then send frame 4(last): result is out_max=4, out_count=1. No result is ever emitted for the aborted frame.
- Back-to-back frames 1(last) then 8,3(last): second result out_max=8, out_count=2. Exactly one bubble cycle with in_ready=0 between frames.
